tri_deskew: RTL
===============

# tri_deskew

- Realigns the skewed, staggered outputs of the systolic array into whole row vectors. Lane j of a row arrives j cycles after lane 0.
- Delays lane j by N-1-j cycles so all lanes of a row line up, then writes the aligned row into a small FIFO drained by a valid/ready handshake.
- It is the output-side counterpart to the input skew stage: that stage staggers rows going into the array, and this block removes the stagger coming out.
- It also raises sticky flags for dropped rows and lane-valid mismatches.

## Interface
- N, 8, number of lanes (array columns)
- DATA_W, 16, bits per lane element
- DEPTH, 4, row FIFO depth in rows (≥2)
- clk  input  1  clock; single clock domain
- rst  input  1  synchronous, active-high reset
- data_i  input  DATA_W×N (unpacked [N])  skewed lane data from array
- valid_i  input  N  per-lane valid, skewed identically to data_i
- data_o  output  DATA_W×N (unpacked [N])  aligned row at FIFO head
- valid_o  output  1  FIFO non-empty
- ready_i  input  1  consumer accepts data_o this cycle
- count_o  output  $clog2(DEPTH+1)  rows currently held in FIFO
- overflow_o  output  1  sticky: an aligned row was dropped (FIFO full)
- misalign_o  output  1  sticky: aligned lane valids disagreed

## Operation
- **Lane delay:** lane j carries {valid_i[j], data_i[j]} through a DATA_W+1-wide delay of N-1-j registered stages. Lane N-1 has zero stages and passes through combinationally. The delays are always enabled, because the array cannot stall.
- **Aligned row:** if lane 0 enters at cycle t and lane j at t+j, all lanes are present at the delay outputs in cycle t+N-1.
- **Push:** occurs when the aligned lane-0 valid is high. All N aligned data words are written as one row, regardless of the other lanes' valids.
- **Misalign:** in any cycle where the aligned valids are not all equal, set misalign_o. It holds until rst.
- **Pop:** occurs when valid_o && ready_i. data_o shows the head row and holds stable while valid_o=1 and ready_i=0.
- **Push and pop together:**
  - Allowed at any occupancy, including full: the pop frees the slot and the push is accepted.
  - count_o is unchanged and overflow_o is not set.
- **Push while full without pop:** the row is dropped and overflow_o is set (sticky). FIFO contents are unaffected.
- **Pop while empty:** impossible, since valid_o=0. ready_i is ignored.
- **Arithmetic:** count_o increments on push-only and decrements on pop-only. Read/write pointers wrap modulo DEPTH. DEPTH need not be a power of two.

## Timing
- **Reset:**
  - All delay stages clear (valid bits 0).
  - FIFO becomes empty, pointers 0.
  - valid_o=0, count_o=0, overflow_o=0, misalign_o=0, data_o=0.
- **rst mid-operation:** rows in flight in the delays and rows in the FIFO are discarded. Outputs take their reset values in the cycle after the rst edge.
- **Latency:** lane-0 element at cycle t gives valid_o=1 with that row in cycle t+N, when the FIFO was empty. There is no bypass path.
- **Throughput:** one row per cycle, sustained when ready_i=1.
- **Flag timing:** overflow_o and misalign_o assert in the cycle after the triggering condition.

## Structure
- **Shared package:** holds the lane-word typedef (logic [DATA_W-1:0]) and the default N and DATA_W, shared with the input skew stage.
- **Lane delays:** instantiate the existing `shift` module per lane 0..N-2, with width_p=DATA_W+1, depth_p=N-1-j, enable_i tied to 1, and the last tap taken as output.
- **Row storage:** one new sub-module, `row_fifo` (parameters DEPTH and row width N×DATA_W). It contains the storage, pointers, count and full/empty logic. The top level keeps only the sticky flags and the misalign compare.

## Test plan
- **Single row:** N=4; drive lane j=0x10+j with valid_i[j]=1 at cycle j from t=0; ready_i=1.
  - Required: valid_o=1 only in cycle 4, data_o={0x10,0x11,0x12,0x13}, count_o returns to 0.
- **Streaming:** six back-to-back skewed rows with values 0x100·r+j; ready_i=1.
  - Required: six consecutive valid_o cycles starting at cycle 4, rows in order, no flags.
- **Overflow:** ready_i=0; push 5 rows into DEPTH=4.
  - Required: count_o=4, overflow_o=1; after raising ready_i, rows 0–3 drain in order and row 4 is absent.
- **Full with concurrent pop:** FIFO full, ready_i=1, new aligned row arrives the same cycle.
  - Required: count_o stays 4, overflow_o=0, the new row appears as the last of the four.
- **Misalign:** N=4, lane 2 valid driven one cycle late.
  - Required: misalign_o=1 from the following cycle; the row is still pushed on the lane-0 valid; the flag persists until rst.
- **Reset mid-stream:** rst for one cycle while 2 rows are in the FIFO and 1 is in the delays.
  - Required: next cycle valid_o=0, count_o=0, flags 0; no stale row ever appears on valid_o afterwards.

Source files
------------

// File: rtl/tri_deskew_pkg.sv
// Shared definitions for the systolic-array skew/deskew stages.
// Lane word type, default geometry and sizing helpers.
package tri_deskew_pkg;

  localparam int DEF_N      = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 4;

  typedef logic [DEF_DATA_W-1:0] lane_t;

  // Width needed to hold an occupancy value in 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; a DEPTH of 2 still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/tri_deskew_if.sv
// Bus between the systolic array output, the deskew block and its row consumer.
// The slave modport is the deskew side; the master modport is the surrounding logic.
interface tri_deskew_if
  import tri_deskew_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  logic [DATA_W-1:0]             data_i [N];
  logic [N-1:0]                  valid_i;
  logic [DATA_W-1:0]             data_o [N];
  logic                          valid_o;
  logic                          ready_i;
  logic [count_width(DEPTH)-1:0] count_o;
  logic                          overflow_o;
  logic                          misalign_o;

  modport slave (
    input  data_i, valid_i, ready_i,
    output data_o, valid_o, count_o, overflow_o, misalign_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  data_o, valid_o, count_o, overflow_o, misalign_o
  );

endinterface

// File: rtl/shift.sv
// Fixed-length register delay line; the last tap is the output.
// depth_p must be at least 1.
module shift #(
  parameter int width_p = 1,
  parameter int depth_p = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] stage_reg [depth_p];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth_p; i++) begin
        stage_reg[i] <= '0;
      end
    end else if (enable_i) begin
      stage_reg[0] <= data_i;
      for (int i = 1; i < depth_p; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign data_o = stage_reg[depth_p-1];

endmodule

// File: rtl/tri_deskew_row_fifo.sv
// Row FIFO for the deskew stage: array storage, wrapping pointers, occupancy,
// and a registered head row so the consumer sees a stable word with no bypass.
module row_fifo
  import tri_deskew_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ROW_W = DEF_N * DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [ROW_W-1:0]              wr_row,
  input  logic                          ready,
  output logic [ROW_W-1:0]              head_row,
  output logic                          not_empty,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          drop
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [ROW_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [ROW_W-1:0] head_reg;
  logic             full, empty, pop, accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count_reg == CNT_W'(DEPTH));
  assign empty  = (count_reg == '0);
  assign pop    = !empty && ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (accept) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (pop)    rd_ptr_next = ptr_inc(rd_ptr_reg);
    if (accept && !pop)      count_next = count_reg + 1'b1;
    else if (!accept && pop) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_reg] <= wr_row;
  end

  // Head register tracks mem[rd_ptr]; the entry behind the head is read one
  // cycle ahead, or the incoming row is taken when it becomes the new head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (pop) begin
        if (count_reg > CNT_W'(1)) head_reg <= mem[ptr_inc(rd_ptr_reg)];
        else if (accept)           head_reg <= wr_row;
        else                       head_reg <= '0;
      end else if (empty && accept) begin
        head_reg <= wr_row;
      end
    end
  end

  assign head_row  = head_reg;
  assign not_empty = !empty;
  assign count     = count_reg;

endmodule

// File: rtl/tri_deskew.sv
// Removes the per-lane stagger from the systolic array output and queues whole
// rows for a valid/ready consumer, with sticky drop and lane-misalignment flags.
module tri_deskew
  import tri_deskew_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic        clk,
  input logic        rst,
  tri_deskew_if.slave bus
);

  localparam int ROW_W = N * DATA_W;

  logic [N-1:0]     aligned_valid;
  logic [ROW_W-1:0] aligned_row;
  logic [ROW_W-1:0] head_row;
  logic             push, drop, lanes_disagree;
  logic             overflow_reg, misalign_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DATA_W:0] tap;
      // Lane j arrives j cycles late, so it is held back N-1-j cycles.
      if (gi < N - 1) begin : g_dly
        shift #(
          .width_p(DATA_W + 1),
          .depth_p(N - 1 - gi)
        ) u_shift (
          .clk      (clk),
          .rst      (rst),
          .enable_i (1'b1),
          .data_i   ({bus.valid_i[gi], bus.data_i[gi]}),
          .data_o   (tap)
        );
      end else begin : g_pass
        assign tap = {bus.valid_i[gi], bus.data_i[gi]};
      end
      assign aligned_valid[gi]                   = tap[DATA_W];
      assign aligned_row[gi*DATA_W +: DATA_W]    = tap[DATA_W-1:0];
      assign bus.data_o[gi]                      = head_row[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign push           = aligned_valid[0];
  assign lanes_disagree = (aligned_valid != '0) && (aligned_valid != '1);

  row_fifo #(
    .DEPTH (DEPTH),
    .ROW_W (ROW_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wr_row    (aligned_row),
    .ready     (bus.ready_i),
    .head_row  (head_row),
    .not_empty (bus.valid_o),
    .count     (bus.count_o),
    .drop      (drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      overflow_reg <= overflow_reg | drop;
      misalign_reg <= misalign_reg | lanes_disagree;
    end
  end

  assign bus.overflow_o = overflow_reg;
  assign bus.misalign_o = misalign_reg;

endmodule
